// File: rtl/decoded_instr_dispatch.sv
// Decoded-instruction dispatch buffer.
// Holds decoded instructions in a small in-order circular FIFO and offers
// the head entry to either the integer ALU or the load/store unit through
// per-unit valid/ready handshakes. Backpressure goes upstream via stall_o.
// An instruction presented while full is dropped and flagged in overflow_o.
module decoded_instr_dispatch #(
  parameter int opcodeWidth    = 6,
  parameter int regWidth       = 5,
  parameter int addressSize    = 64,
  parameter int XxoOpcodeWidth = 10,
  parameter int formatWidth    = 5,
  parameter int depth          = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic [addressSize-1:0]    instructionAddress_i,
  input  logic [opcodeWidth-1:0]    opcode_i,
  input  logic [XxoOpcodeWidth-1:0] xOpcode_i,
  input  logic [formatWidth-1:0]    instructionFormat_i,
  input  logic [63:0]               imm_i,
  input  logic [regWidth-1:0]       reg1_i,
  input  logic [regWidth-1:0]       reg2_i,
  input  logic [regWidth-1:0]       reg3_i,
  input  logic                      immEnable_i,
  input  logic                      reg1Enable_i,
  input  logic                      reg2Enable_i,
  input  logic                      reg3Enable_i,
  input  logic                      reg3IsImmediate_i,
  input  logic                      bit1_i,
  input  logic                      bit2_i,
  input  logic                      bit1Enable_i,
  input  logic                      bit2Enable_i,
  input  logic                      reg2ValOrZero_i,
  input  logic                      xOpcodeEnable_i,
  output logic                      stall_o,
  output logic                      overflow_o,
  output logic                      aluValid_o,
  input  logic                      aluReady_i,
  output logic                      lsuValid_o,
  input  logic                      lsuReady_i,
  output logic [addressSize-1:0]    instructionAddress_o,
  output logic [opcodeWidth-1:0]    opcode_o,
  output logic [XxoOpcodeWidth-1:0] xOpcode_o,
  output logic [formatWidth-1:0]    instructionFormat_o,
  output logic [63:0]               imm_o,
  output logic [regWidth-1:0]       reg1_o,
  output logic [regWidth-1:0]       reg2_o,
  output logic [regWidth-1:0]       reg3_o,
  output logic                      immEnable_o,
  output logic                      reg1Enable_o,
  output logic                      reg2Enable_o,
  output logic                      reg3Enable_o,
  output logic                      reg3IsImmediate_o,
  output logic                      bit1_o,
  output logic                      bit2_o,
  output logic                      bit1Enable_o,
  output logic                      bit2Enable_o,
  output logic                      reg2ValOrZero_o,
  output logic                      xOpcodeEnable_o
);

  localparam int ptrWidth     = $clog2(depth);
  localparam int cntWidth     = ptrWidth + 1;
  localparam int flagWidth    = 11;
  localparam int payloadWidth = addressSize + opcodeWidth + XxoOpcodeWidth + formatWidth
                              + 64 + 3 * regWidth + flagWidth;
  localparam logic [cntWidth-1:0] fullCount = cntWidth'(depth);

  logic [payloadWidth-1:0] fifo_mem [depth];
  logic [ptrWidth-1:0]     wr_ptr;
  logic [ptrWidth-1:0]     rd_ptr;
  logic [cntWidth-1:0]     count;
  logic                    overflow_q;
  logic [payloadWidth-1:0] wr_payload;
  logic                    not_empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  logic                    head_is_lsu;

  assign wr_payload = {instructionAddress_i, opcode_i, xOpcode_i, instructionFormat_i, imm_i,
                       reg1_i, reg2_i, reg3_i,
                       immEnable_i, reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i,
                       bit1_i, bit2_i, bit1Enable_i, bit2Enable_i, reg2ValOrZero_i,
                       xOpcodeEnable_i};

  // Head entry drives the shared payload bus; meaningless while empty.
  assign {instructionAddress_o, opcode_o, xOpcode_o, instructionFormat_o, imm_o,
          reg1_o, reg2_o, reg3_o,
          immEnable_o, reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o,
          bit1_o, bit2_o, bit1Enable_o, bit2Enable_o, reg2ValOrZero_o,
          xOpcodeEnable_o} = fifo_mem[rd_ptr];

  // Full/drop decisions use the pre-edge count, so a pop while full never
  // makes room for a push in the same cycle.
  assign not_empty  = (count != '0);
  assign full       = (count == fullCount);
  assign stall_o    = full;
  assign overflow_o = overflow_q;
  assign push       = enable_i & ~full;
  assign pop        = (aluValid_o & aluReady_i) | (lsuValid_o & lsuReady_i);

  // Route the head: loads/stores go to the LSU, everything else to the ALU.
  always_comb begin
    head_is_lsu = 1'b0;
    if (opcode_o >= opcodeWidth'(32) && opcode_o <= opcodeWidth'(47))
      head_is_lsu = 1'b1;
    if (opcode_o == opcodeWidth'(56) || opcode_o == opcodeWidth'(57) ||
        opcode_o == opcodeWidth'(58) || opcode_o == opcodeWidth'(61) ||
        opcode_o == opcodeWidth'(62))
      head_is_lsu = 1'b1;
  end

  assign aluValid_o = not_empty & ~head_is_lsu;
  assign lsuValid_o = not_empty &  head_is_lsu;

  // Pointers, occupancy and sticky overflow; reset flushes every entry.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptrWidth'(1);
      if (pop)  rd_ptr <= rd_ptr + ptrWidth'(1);
      if (push && !pop)
        count <= count + cntWidth'(1);
      else if (pop && !push)
        count <= count - cntWidth'(1);
      if (enable_i && full) overflow_q <= 1'b1;
    end
  end

  // Payload storage needs no reset; the pointers decide what is live.
  always_ff @(posedge clock_i) begin
    if (push) fifo_mem[wr_ptr] <= wr_payload;
  end

endmodule

// File: tb/tb_decoded_instr_dispatch.sv
// Self-checking bench for decoded_instr_dispatch: directed scenarios plus a
// randomized phase, compared against a queue-based reference model.
module tb_decoded_instr_dispatch;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [63:0] addr;
    logic [5:0]  op;
    logic [9:0]  xop;
    logic [4:0]  fmt;
    logic [63:0] imm;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  r3;
    logic [10:0] flags;
  } instr_t;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        enable_i;
  logic [63:0] instructionAddress_i;
  logic [5:0]  opcode_i;
  logic [9:0]  xOpcode_i;
  logic [4:0]  instructionFormat_i;
  logic [63:0] imm_i;
  logic [4:0]  reg1_i, reg2_i, reg3_i;
  logic        immEnable_i, reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i;
  logic        bit1_i, bit2_i, bit1Enable_i, bit2Enable_i, reg2ValOrZero_i, xOpcodeEnable_i;
  logic        stall_o, overflow_o, aluValid_o, lsuValid_o;
  logic        aluReady_i, lsuReady_i;
  logic [63:0] instructionAddress_o;
  logic [5:0]  opcode_o;
  logic [9:0]  xOpcode_o;
  logic [4:0]  instructionFormat_o;
  logic [63:0] imm_o;
  logic [4:0]  reg1_o, reg2_o, reg3_o;
  logic        immEnable_o, reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o;
  logic        bit1_o, bit2_o, bit1Enable_o, bit2Enable_o, reg2ValOrZero_o, xOpcodeEnable_o;

  decoded_instr_dispatch dut (
    .clock_i(clock_i), .reset_i(reset_i), .enable_i(enable_i),
    .instructionAddress_i(instructionAddress_i), .opcode_i(opcode_i),
    .xOpcode_i(xOpcode_i), .instructionFormat_i(instructionFormat_i), .imm_i(imm_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .reg3_i(reg3_i),
    .immEnable_i(immEnable_i), .reg1Enable_i(reg1Enable_i), .reg2Enable_i(reg2Enable_i),
    .reg3Enable_i(reg3Enable_i), .reg3IsImmediate_i(reg3IsImmediate_i),
    .bit1_i(bit1_i), .bit2_i(bit2_i), .bit1Enable_i(bit1Enable_i), .bit2Enable_i(bit2Enable_i),
    .reg2ValOrZero_i(reg2ValOrZero_i), .xOpcodeEnable_i(xOpcodeEnable_i),
    .stall_o(stall_o), .overflow_o(overflow_o),
    .aluValid_o(aluValid_o), .aluReady_i(aluReady_i),
    .lsuValid_o(lsuValid_o), .lsuReady_i(lsuReady_i),
    .instructionAddress_o(instructionAddress_o), .opcode_o(opcode_o),
    .xOpcode_o(xOpcode_o), .instructionFormat_o(instructionFormat_o), .imm_o(imm_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .immEnable_o(immEnable_o), .reg1Enable_o(reg1Enable_o), .reg2Enable_o(reg2Enable_o),
    .reg3Enable_o(reg3Enable_o), .reg3IsImmediate_o(reg3IsImmediate_o),
    .bit1_o(bit1_o), .bit2_o(bit2_o), .bit1Enable_o(bit1Enable_o), .bit2Enable_o(bit2Enable_o),
    .reg2ValOrZero_o(reg2ValOrZero_o), .xOpcodeEnable_o(xOpcodeEnable_o)
  );

  always #5 clock_i = ~clock_i;

  int     n_checks = 0;
  int     n_passed = 0;
  instr_t model_q[$];
  logic   model_ovf = 1'b0;
  instr_t cur_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic is_lsu(input logic [5:0] op);
    return op inside {[6'd32:6'd47], 6'd56, 6'd57, 6'd58, 6'd61, 6'd62};
  endfunction

  function automatic instr_t make_instr(input logic [5:0] op);
    instr_t r;
    r.addr  = {$urandom, $urandom};
    r.op    = op;
    r.xop   = 10'($urandom);
    r.fmt   = 5'($urandom_range(0, 25));
    r.imm   = {$urandom, $urandom};
    r.r1    = 5'($urandom);
    r.r2    = 5'($urandom);
    r.r3    = 5'($urandom);
    r.flags = 11'($urandom);
    return r;
  endfunction

  task automatic drive(input instr_t ins, input logic en);
    cur_in = ins;
    enable_i = en;
    instructionAddress_i = ins.addr;
    opcode_i = ins.op;
    xOpcode_i = ins.xop;
    instructionFormat_i = ins.fmt;
    imm_i = ins.imm;
    reg1_i = ins.r1;
    reg2_i = ins.r2;
    reg3_i = ins.r3;
    {immEnable_i, reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i,
     bit1_i, bit2_i, bit1Enable_i, bit2Enable_i, reg2ValOrZero_i, xOpcodeEnable_i} = ins.flags;
  endtask

  // Compare every DUT output against the model's view of the FIFO.
  task automatic check_state();
    instr_t h;
    logic [10:0] fl;
    check("stall", stall_o, model_q.size() == DEPTH);
    check("overflow", overflow_o, model_ovf);
    check("alu_valid", aluValid_o, model_q.size() > 0 && !is_lsu(model_q[0].op));
    check("lsu_valid", lsuValid_o, model_q.size() > 0 && is_lsu(model_q[0].op));
    if (model_q.size() > 0) begin
      h  = model_q[0];
      fl = {immEnable_o, reg1Enable_o, reg2Enable_o, reg3Enable_o, reg3IsImmediate_o,
            bit1_o, bit2_o, bit1Enable_o, bit2Enable_o, reg2ValOrZero_o, xOpcodeEnable_o};
      check("addr", instructionAddress_o, h.addr);
      check("opcode", opcode_o, h.op);
      check("xopcode", xOpcode_o, h.xop);
      check("format", instructionFormat_o, h.fmt);
      check("imm", imm_o, h.imm);
      check("reg1", reg1_o, h.r1);
      check("reg2", reg2_o, h.r2);
      check("reg3", reg3_o, h.r3);
      check("flags", fl, h.flags);
    end
  endtask

  // One clock: decide model pop/push from pre-edge state, apply at the edge,
  // then compare at the following falling edge.
  task automatic tick();
    logic do_pop, do_push;
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (reset_i) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (model_q.size() > 0)
        do_pop = is_lsu(model_q[0].op) ? lsuReady_i : aluReady_i;
      do_push = enable_i && (model_q.size() < DEPTH);
      if (enable_i && model_q.size() == DEPTH) model_ovf = 1'b1;
    end
    @(posedge clock_i);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(cur_in);
    @(negedge clock_i);
    check_state();
  endtask

  initial begin
    instr_t ins;
    reset_i = 1'b1;
    aluReady_i = 1'b0;
    lsuReady_i = 1'b0;
    drive(make_instr(6'd0), 1'b0);
    #12;
    check_state();
    @(negedge clock_i);
    reset_i = 1'b0;
    tick();

    // Single ALU op
    ins = make_instr(6'd14);
    ins.imm = 64'h5;
    aluReady_i = 1'b1;
    drive(ins, 1'b1);
    tick();
    check("single_alu_valid", aluValid_o, 1);
    check("single_imm", imm_o, 64'h5);
    drive(make_instr(6'd0), 1'b0);
    tick();
    check("single_drained_alu_valid", aluValid_o, 0);

    // Mixed stream with LSU backpressure
    lsuReady_i = 1'b0;
    drive(make_instr(6'd32), 1'b1); tick();
    drive(make_instr(6'd31), 1'b1); tick();
    drive(make_instr(6'd36), 1'b1); tick();
    drive(make_instr(6'd0), 1'b0);
    tick(); tick();
    check("mixed_head_op", opcode_o, 6'd32);
    check("mixed_lsu_held", lsuValid_o, 1);
    lsuReady_i = 1'b1;
    tick();
    check("mixed_second_op", opcode_o, 6'd31);
    tick();
    check("mixed_third_op", opcode_o, 6'd36);
    tick(); tick();

    // Fill and overflow
    aluReady_i = 1'b0;
    lsuReady_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(make_instr(6'($urandom)), 1'b1);
      tick();
    end
    check("fill_stall", stall_o, 1);
    check("fill_overflow", overflow_o, 1);
    drive(make_instr(6'd0), 1'b0);
    aluReady_i = 1'b1;
    lsuReady_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Full with simultaneous push and pop
    aluReady_i = 1'b0;
    lsuReady_i = 1'b0;
    drive(make_instr(6'd14), 1'b1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(make_instr(6'($urandom)), 1'b1);
      tick();
    end
    aluReady_i = 1'b1;
    drive(make_instr(6'd20), 1'b1);
    tick();
    check("full_pushpop_stall", stall_o, 0);
    drive(make_instr(6'd0), 1'b0);
    lsuReady_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Wrap-around: 12 push/pop pairs
    drive(make_instr(6'($urandom)), 1'b1); tick();
    for (int i = 0; i < 12; i++) begin
      drive(make_instr(6'($urandom)), 1'b1);
      tick();
    end
    drive(make_instr(6'd0), 1'b0);
    tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      aluReady_i = 1'($urandom);
      lsuReady_i = 1'($urandom);
      drive(make_instr(6'($urandom)), 1'($urandom));
      tick();
    end
    aluReady_i = 1'b1;
    lsuReady_i = 1'b1;
    drive(make_instr(6'd0), 1'b0);
    for (int i = 0; i < 5; i++) tick();

    // Async reset mid-stream with 3 entries
    aluReady_i = 1'b0;
    lsuReady_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(make_instr(6'($urandom)), 1'b1);
      tick();
    end
    drive(make_instr(6'd0), 1'b0);
    aluReady_i = 1'b1;
    lsuReady_i = 1'b1;
    #2 reset_i = 1'b1;
    #1;
    check("rst_alu_valid", aluValid_o, 0);
    check("rst_lsu_valid", lsuValid_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_overflow", overflow_o, 0);
    model_q.delete();
    model_ovf = 1'b0;
    tick();
    reset_i = 1'b0;
    drive(make_instr(6'd40), 1'b1);
    tick();
    check("post_rst_lsu_valid", lsuValid_o, 1);
    drive(make_instr(6'd0), 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/decoded_instr_dispatch.md
# decoded_instr_dispatch

Buffers the single decoded-instruction bus produced by the second decode stage and dispatches each instruction to either the integer ALU or the load/store unit. It uses a per-unit valid/ready handshake. The block sits between decode stage 2 and the execution units, absorbs execution-side stalls in a small in-order FIFO, and signals backpressure upstream.

## Interface
- opcodeWidth, 6, primary opcode width
- regWidth, 5, register index width
- addressSize, 64, instruction address width
- XxoOpcodeWidth, 10, extended opcode width
- formatWidth, 5, instruction format code width (encodings 0..25 as defined for decode)
- depth, 4, FIFO entries (power of two, ≥2)
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- enable_i  in  1  decoded instruction valid this cycle
- instructionAddress_i, opcode_i, xOpcode_i, instructionFormat_i  in  addressSize/opcodeWidth/XxoOpcodeWidth/formatWidth  identifiers
- imm_i  in  64  immediate
- reg1_i, reg2_i, reg3_i  in  regWidth each  register indices
- immEnable_i, reg1Enable_i, reg2Enable_i, reg3Enable_i, reg3IsImmediate_i, bit1_i, bit2_i, bit1Enable_i, bit2Enable_i, reg2ValOrZero_i, xOpcodeEnable_i  in  1 each  decode flags
- stall_o  out  1  FIFO full; upstream must not present enable_i
- overflow_o  out  1  sticky: an instruction arrived while full and was dropped
- aluValid_o  out  1  head instruction offered to ALU
- aluReady_i  in  1  ALU accepts
- lsuValid_o  out  1  head instruction offered to LSU
- lsuReady_i  in  1  LSU accepts
- Payload outputs: all *_i payload fields mirrored as *_o, driven from the FIFO head and shared by both units

## Operation
- Storage: depth-entry circular FIFO holding the full payload; write pointer, read pointer, occupancy count of width log2(depth)+1.
- Push: enable_i=1 and count<depth → write the entry at wrPtr, wrPtr+1 (mod depth).
- Dropped push: enable_i=1 and count==depth → entry discarded, overflow_o set to 1 until reset, FIFO unchanged.
- Classification from head opcode: LSU if opcode ∈ {32..47, 56, 57, 58, 61, 62}; otherwise ALU.
- Offer: count>0 → exactly one of aluValid_o/lsuValid_o = 1 per the classification; count==0 → both 0.
- Pop: (aluValid_o & aluReady_i) | (lsuValid_o & lsuReady_i) → rdPtr+1 (mod depth). A ready signal on the non-offered unit is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance. A pop while full frees no space for the same-cycle push, because stall_o and the drop check use the pre-edge count.
- Strictly in order: a blocked head stalls all later entries, including those destined for the other unit.
- Payload outputs are combinational from the head entry; they are don't-care when count==0.

## Timing
- Reset (async, immediate): wrPtr=rdPtr=count=0, overflow_o=0, stall_o=0, aluValid_o=lsuValid_o=0.
- Latency: instruction pushed at edge N appears at the head no earlier than the cycle after edge N. There is no same-cycle bypass, even when empty.
- Throughput: one push and one pop per cycle.
- stall_o = (count==depth), combinational from registered count.
- Valid/ready: once asserted, valid and payload hold stable until the pop edge. The downstream unit may hold ready high permanently.
- Pointer wrap: depth-1 → 0 on both push and pop.
- Reset asserted mid-stream flushes all entries; no handshake is completed in that cycle.

## Test plan
- Single ALU op: push opcode 14 (addi, imm 0x0005) into an empty FIFO with aluReady_i=1 → aluValid_o high the next cycle with imm_o=0x5, popped at the following edge, count back to 0, lsuValid_o never high.
- Mixed stream with backpressure: push 32 (lwz), 31 (X), 36 (stw) with lsuReady_i=0 → lsuValid_o held with opcode_o=32 and the ALU op waits; raise lsuReady_i → dispatch order 32, 31, 36.
- Fill and overflow: push 5 instructions with both readies 0 → stall_o=1 after the 4th push, 5th dropped, overflow_o=1, then drain returns exactly 4 entries in order.
- Full with simultaneous push and pop: FIFO full, aluReady_i=1 on an ALU head, enable_i=1 → head popped, new entry dropped, overflow_o=1, count=3.
- Wrap-around: 12 consecutive push/pop pairs at depth 4 → every payload field (address, regs, bits, xOpcode) emerges unchanged and in order.
- Async reset mid-stream with 3 entries → all outputs take reset values immediately without a clock edge, and a post-reset push behaves as for an empty FIFO.
